// File: rtl/soda_vend_pkg.sv
// Shared state encoding, coin codes and coin valuation for the soda vending controller.
package soda_vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_CHANGE = 3'd2,
    ST_REFUND = 3'd3,
    ST_VEND   = 3'd4,
    ST_EMPTY  = 3'd5
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_FIVE = 2'b11;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    logic [2:0] val;
    case (code)
      COIN_ONE:  val = 3'd1;
      COIN_TWO:  val = 3'd2;
      COIN_FIVE: val = 3'd5;
      default:   val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/soda_edge_detect.sv
// Registered rising-edge detector: pulse is high for the one clk cycle in which
// 'in' is high but was low at the previous clk edge.
module soda_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  // History of the input, sampled each clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in;
    end
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/soda_vend_ctrl.sv
// Soda vending controller: coin accumulation, greedy change/refund, vend and stock tracking,
// each step triggered by a rising edge of the 'next' button.
module soda_vend_ctrl
  import soda_vend_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next,
  input  logic                cancel,
  input  logic                restock,
  input  logic [1:0]          coin_in,
  output logic                soda,
  output logic [1:0]          coin_out,
  output logic [2:0]          state_display,
  output logic                check_coin_in,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out
);

  if (PRICE < 1 || PRICE > 15) begin : g_bad_price
    $error("soda_vend_ctrl: PRICE must be in 1..15");
  end
  if ((2 ** CREDIT_W) - 1 < PRICE + 4) begin : g_bad_credit_w
    $error("soda_vend_ctrl: CREDIT_W too narrow to hold PRICE+4");
  end
  if (STOCK_INIT < 1 || STOCK_INIT > (2 ** STOCK_W) - 1) begin : g_bad_stock
    $error("soda_vend_ctrl: STOCK_INIT out of range for STOCK_W");
  end

  localparam logic [CREDIT_W:0]   PRICE_C      = (CREDIT_W + 1)'(PRICE);
  localparam logic [STOCK_W-1:0]  STOCK_INIT_C = STOCK_W'(STOCK_INIT);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q, stock_d;
  logic                 step_s;
  logic [CREDIT_W:0]    sum_s;
  logic [CREDIT_W-1:0]  diff_s;
  logic [CREDIT_W-1:0]  dec_s;

  soda_edge_detect u_next_edge (
    .clk   (clk),
    .reset (reset),
    .in    (next),
    .pulse (step_s)
  );

  // Widened sum keeps the PRICE comparison exact; the worst case is PRICE-1+5
  assign sum_s  = {1'b0, credit_q} + {{(CREDIT_W - 2){1'b0}}, coin_value(coin_in)};
  assign diff_s = CREDIT_W'(sum_s - PRICE_C);
  assign dec_s  = (credit_q >= CREDIT_W'(2)) ? credit_q - CREDIT_W'(2)
                                             : credit_q - CREDIT_W'(1);

  // State, credit and stock registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= {CREDIT_W{1'b0}};
      stock_q  <= STOCK_INIT_C;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
    end
  end

  // Next-state, credit and stock update
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (state_q == ST_IDLE && restock) begin
          stock_d = STOCK_INIT_C;
        end else begin
          stock_d = stock_q;
        end
        if (!step_s) begin
          state_d = state_q;
        end else if (cancel && state_q == ST_ACCUM) begin
          state_d = ST_REFUND;
        end else if (sum_s < PRICE_C) begin
          credit_d = sum_s[CREDIT_W-1:0];
          state_d  = (sum_s != '0) ? ST_ACCUM : state_q;
        end else begin
          credit_d = diff_s;
          // Stock never wraps: a sale at zero stock leaves it at zero
          if (stock_d != '0) begin
            stock_d = stock_d - STOCK_W'(1);
          end else begin
            stock_d = stock_d;
          end
          state_d = (diff_s != '0) ? ST_CHANGE : ST_VEND;
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (step_s) begin
          credit_d = (credit_q == '0) ? credit_q : dec_s;
          if (credit_d == '0) begin
            state_d = (state_q == ST_CHANGE) ? ST_VEND : ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          credit_d = credit_q;
        end
      end
      ST_VEND: begin
        if (step_s) begin
          state_d = (stock_q == '0) ? ST_EMPTY : ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_EMPTY: begin
        if (restock) begin
          stock_d = STOCK_INIT_C;
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    soda          = (state_q == ST_VEND);
    sold_out      = (state_q == ST_EMPTY);
    check_coin_in = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    state_display = state_q;
    credit        = credit_q;
    if (state_q == ST_CHANGE || state_q == ST_REFUND) begin
      coin_out = (credit_q >= CREDIT_W'(2)) ? COIN_TWO : COIN_ONE;
    end else begin
      coin_out = COIN_NONE;
    end
  end

endmodule

// File: tb/tb_soda_vend_ctrl.sv
// Scoreboard bench for soda_vend_ctrl: a rule-level model queues expected outputs per cycle,
// and an independent monitor compares them against the DUT after each clk edge.
module tb_soda_vend_ctrl;

  localparam int P  = 3;
  localparam int CW = 4;
  localparam int SI = 4;

  typedef struct packed {
    logic          soda;
    logic [1:0]    co;
    logic [2:0]    st;
    logic          chk;
    logic [CW-1:0] cr;
    logic          so;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          next = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [1:0]    coin_in = 2'b00;
  logic          soda, check_coin_in, sold_out;
  logic [1:0]    coin_out;
  logic [2:0]    state_display;
  logic [CW-1:0] credit;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic force_chk = 1'b0;

  // Model state in plain integers; names follow the behavioural description
  localparam int IDLE = 0, ACCUM = 1, CHANGE = 2, REFUND = 3, VEND = 4, EMPTY = 5;
  int m_st = IDLE, m_cr = 0, m_stock = SI;
  bit m_prev = 1'b0;

  soda_vend_ctrl #(.PRICE(P), .CREDIT_W(CW), .STOCK_W(4), .STOCK_INIT(SI)) dut (
    .clk(clk), .reset(reset), .next(next), .cancel(cancel), .restock(restock),
    .coin_in(coin_in), .soda(soda), .coin_out(coin_out), .state_display(state_display),
    .check_coin_in(check_coin_in), .credit(credit), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  function automatic int coin_units(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.soda = (m_st == VEND);
    e.co   = (m_st == CHANGE || m_st == REFUND) ? ((m_cr >= 2) ? 2'b10 : 2'b01) : 2'b00;
    e.st   = 3'(m_st);
    e.chk  = (m_st == IDLE || m_st == ACCUM);
    e.cr   = CW'(m_cr);
    e.so   = (m_st == EMPTY);
    return e;
  endfunction

  function automatic void model_reset();
    m_st = IDLE; m_cr = 0; m_stock = SI; m_prev = 1'b0;
  endfunction

  function automatic void model_clock(input bit n, input bit c, input bit r, input logic [1:0] ci);
    bit stp;
    int sum;
    stp    = n && !m_prev;
    m_prev = n;
    case (m_st)
      IDLE, ACCUM: begin
        if (m_st == IDLE && r) m_stock = SI;
        if (stp) begin
          sum = m_cr + coin_units(ci);
          if (c && m_st == ACCUM) m_st = REFUND;
          else if (sum < P) begin
            m_cr = sum;
            if (sum > 0) m_st = ACCUM;
          end else begin
            m_cr = sum - P;
            if (m_stock > 0) m_stock--;
            m_st = (m_cr > 0) ? CHANGE : VEND;
          end
        end
      end
      CHANGE, REFUND: if (stp) begin
        m_cr -= (m_cr >= 2) ? 2 : 1;
        if (m_cr == 0) m_st = (m_st == CHANGE) ? VEND : IDLE;
      end
      VEND: if (stp) m_st = (m_stock == 0) ? EMPTY : IDLE;
      EMPTY: if (r) begin
        m_stock = SI;
        m_st    = IDLE;
      end
      default: m_st = IDLE;
    endcase
  endfunction

  task automatic drive(input bit n, input bit c, input bit r, input logic [1:0] ci);
    @(negedge clk);
    next = n; cancel = c; restock = r; coin_in = ci;
    model_clock(n, c, r, ci);
    sb.push_back(model_out());
  endtask

  task automatic press(input bit c, input logic [1:0] ci);
    drive(1'b1, c, 1'b0, ci);
    drive(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic async_reset_check();
    exp_t e;
    e = '{soda: 1'b0, co: 2'b00, st: 3'd0, chk: 1'b1, cr: '0, so: 1'b0};
    sb.push_back(e);
    force_chk = 1'b1;
    #2 force_chk = 1'b0;
  endtask

  // Monitor: compare the oldest expectation whenever one is pending
  always begin : monitor
    exp_t e, a;
    @(posedge clk or posedge force_chk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{soda: soda, co: coin_out, st: state_display, chk: check_coin_in, cr: credit, so: sold_out};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t actual soda=%b co=%b st=%0d chk=%b cr=%0d so=%b required soda=%b co=%b st=%0d chk=%b cr=%0d so=%b",
                 $time, a.soda, a.co, a.st, a.chk, a.cr, a.so, e.soda, e.co, e.st, e.chk, e.cr, e.so);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2;
    async_reset_check();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00);

    press(1'b0, 2'b10);                 // ACCUM credit 2
    press(1'b0, 2'b01);                 // VEND
    press(1'b0, 2'b00);                 // back to IDLE
    press(1'b0, 2'b11);                 // CHANGE credit 2
    press(1'b0, 2'b00);                 // VEND
    press(1'b0, 2'b00);
    press(1'b0, 2'b01);                 // ACCUM 1
    press(1'b0, 2'b11);                 // CHANGE credit 3
    press(1'b0, 2'b00);                 // credit 1
    press(1'b0, 2'b00);                 // VEND
    press(1'b0, 2'b00);
    press(1'b1, 2'b10);                 // cancel in IDLE ignored, credit 2
    press(1'b1, 2'b11);                 // REFUND credit 2
    press(1'b0, 2'b00);                 // IDLE credit 0
    press(1'b0, 2'b10);
    press(1'b0, 2'b01);                 // last unit sold
    press(1'b0, 2'b00);                 // EMPTY
    press(1'b0, 2'b11);                 // ignored while EMPTY
    drive(1'b0, 1'b0, 1'b1, 2'b00);     // restock
    drive(1'b0, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 2'b00);

    press(1'b0, 2'b11);                 // into CHANGE, then reset mid-change
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    #2 reset = 1'b0;
    async_reset_check();
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      bit n, c, r;
      n = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 4) == 0);
      r = !(n && !m_prev) && ($urandom_range(0, 5) == 0);
      drive(n, c, r, 2'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
